// File: rtl/data_ram_bw.sv
// Byte-lane-write data RAM for the MA stage with a clear engine,
// optional output register and selectable read-during-write forwarding.
module data_ram_bw #(
  parameter int AW         = 10,
  parameter int NB         = 4,
  parameter int OREG       = 0,
  parameter int BYPASS     = 1,
  parameter int CLR_ON_RST = 1,
  localparam int DW        = 8 * NB,
  localparam int DEPTH     = 2 ** AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ram_ren,
  input  logic [AW-1:0] ram_radr,
  output logic [DW-1:0] ram_rdata,
  output logic          ram_rvalid,
  input  logic [NB-1:0] ram_wen,
  input  logic [AW-1:0] ram_wadr,
  input  logic [DW-1:0] ram_wdata,
  output logic          init_busy
);

  localparam bit CLR = (CLR_ON_RST != 0);
  localparam bit BYP = (BYPASS != 0);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_we;

  logic [DW-1:0] mem_q [DEPTH];

  logic          rd_acc;
  logic          wr_acc;
  logic [DW-1:0] rd_w;

  logic [DW-1:0] rdata_q;
  logic          rvalid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLR ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (cnt_q == '1) state_d = READY;
      end
      READY: begin
      end
    endcase
  end

  assign rd_acc = rst_n && (state_q == READY) && ram_ren;
  assign wr_acc = rst_n && (state_q == READY);

  always_ff @(posedge clk) begin
    if (rst_n && clr_we) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (ram_wen[i]) begin
          mem_q[ram_wadr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Same-cycle write to the read address is merged lane by lane.
  always_comb begin
    rd_w = mem_q[ram_radr];
    if (BYP && wr_acc && (ram_radr == ram_wadr)) begin
      for (int i = 0; i < NB; i++) begin
        if (ram_wen[i]) rd_w[8*i +: 8] = ram_wdata[8*i +: 8];
      end
    end
  end

  if (OREG != 0) begin : g_oreg
    logic [DW-1:0] s1_data_q;
    logic          s1_vld_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_data_q <= '0;
        s1_vld_q  <= 1'b0;
        rdata_q   <= '0;
        rvalid_q  <= 1'b0;
      end else begin
        s1_vld_q <= rd_acc;
        if (rd_acc) s1_data_q <= rd_w;
        rvalid_q <= s1_vld_q;
        if (s1_vld_q) rdata_q <= s1_data_q;
      end
    end
  end else begin : g_direct
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= rd_w;
      end
    end
  end

  // A strobe already in flight is masked the moment reset is asserted.
  assign ram_rdata  = rdata_q;
  assign ram_rvalid = rvalid_q & rst_n;
  assign init_busy  = (state_q == CLEAR) | (~rst_n & CLR);

endmodule

// File: tb/tb_data_ram_bw.sv
// Directed bench for data_ram_bw: four instances covering OREG,
// BYPASS and CLR_ON_RST variants driven by shared stimulus.
module tb_data_ram_bw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ren;
  logic [3:0]  radr;
  logic [3:0]  wadr;
  logic [3:0]  wen;
  logic [31:0] wdata;

  logic [31:0] rd0, rd1, rd2, rd3;
  logic        rv0, rv1, rv2, rv3;
  logic        bz0, bz1, bz2, bz3;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  data_ram_bw #(.AW(4), .NB(4), .OREG(0), .BYPASS(1), .CLR_ON_RST(1)) u0 (
    .clk(clk), .rst_n(rst_n), .ram_ren(ren), .ram_radr(radr),
    .ram_rdata(rd0), .ram_rvalid(rv0), .ram_wen(wen), .ram_wadr(wadr),
    .ram_wdata(wdata), .init_busy(bz0));

  data_ram_bw #(.AW(4), .NB(4), .OREG(0), .BYPASS(0), .CLR_ON_RST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ram_ren(ren), .ram_radr(radr),
    .ram_rdata(rd1), .ram_rvalid(rv1), .ram_wen(wen), .ram_wadr(wadr),
    .ram_wdata(wdata), .init_busy(bz1));

  data_ram_bw #(.AW(4), .NB(4), .OREG(1), .BYPASS(1), .CLR_ON_RST(1)) u2 (
    .clk(clk), .rst_n(rst_n), .ram_ren(ren), .ram_radr(radr),
    .ram_rdata(rd2), .ram_rvalid(rv2), .ram_wen(wen), .ram_wadr(wadr),
    .ram_wdata(wdata), .init_busy(bz2));

  data_ram_bw #(.AW(4), .NB(4), .OREG(0), .BYPASS(1), .CLR_ON_RST(0)) u3 (
    .clk(clk), .rst_n(rst_n), .ram_ren(ren), .ram_radr(radr),
    .ram_rdata(rd3), .ram_rvalid(rv3), .ram_wen(wen), .ram_wadr(wadr),
    .ram_wdata(wdata), .init_busy(bz3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    int stray;
    rst_n = 1'b0;
    ren   = 1'b0;
    radr  = '0;
    wadr  = '0;
    wen   = '0;
    wdata = '0;
    tick();
    tick();
    chk("rst_busy_clr", 32'(bz0), 32'd1);
    chk("rst_busy_noclr", 32'(bz3), 32'd0);
    chk("rst_rdata", rd0, 32'h0);
    chk("rst_rvalid", 32'(rv0), 32'd0);
    chk("rst_rdata_oreg", rd2, 32'h0);

    // requests during clear must be ignored
    ren   = 1'b1;
    radr  = 4'd3;
    wen   = 4'hF;
    wadr  = 4'd3;
    wdata = 32'hFFFF_FFFF;
    rst_n = 1'b1;
    k     = 0;
    stray = 0;
    do begin
      tick();
      k++;
      if (rv0 | rv1 | rv2) stray++;
      if (k == 1) chk("noclr_rvalid", 32'(rv3), 32'd1);
    end while (bz0 && k < 40);
    ren = 1'b0;
    wen = '0;
    chk("clr_len", 32'(k), 32'd16);
    chk("busy_rvalid", 32'(stray), 32'd0);
    chk("busy_u1", 32'(bz1), 32'd0);

    ren  = 1'b1;
    radr = 4'd3;
    tick();
    ren = 1'b0;
    chk("busy_wr_drop", rd0, 32'h0);
    chk("first_rvalid", 32'(rv0), 32'd1);
    chk("busy_wr_drop_b0", rd1, 32'h0);
    chk("noclr_wr", rd3, 32'hFFFF_FFFF);

    // byte-lane write
    wen   = 4'hF;
    wadr  = 4'd5;
    wdata = 32'h1122_3344;
    tick();
    wen   = 4'b0001;
    wdata = 32'h0000_00AA;
    tick();
    wen  = '0;
    ren  = 1'b1;
    radr = 4'd5;
    tick();
    ren = 1'b0;
    chk("lane_rdata", rd0, 32'h1122_33AA);
    chk("lane_rvalid", 32'(rv0), 32'd1);
    tick();
    chk("lane_rvalid_off", 32'(rv0), 32'd0);
    chk("lane_hold", rd0, 32'h1122_33AA);
    chk("lane_oreg_rvalid", 32'(rv2), 32'd1);
    chk("lane_oreg_rdata", rd2, 32'h1122_33AA);

    // read-during-write forwarding
    wen   = 4'hF;
    wadr  = 4'd7;
    wdata = 32'h0102_0304;
    tick();
    ren   = 1'b1;
    radr  = 4'd7;
    wen   = 4'b0110;
    wdata = 32'hFFEE_DDCC;
    tick();
    chk("fwd_byp1", rd0, 32'h01EE_DD04);
    chk("fwd_byp0", rd1, 32'h0102_0304);
    ren = 1'b0;
    wen = '0;
    tick();
    chk("fwd_oreg_rvalid", 32'(rv2), 32'd1);
    chk("fwd_oreg_rdata", rd2, 32'h01EE_DD04);
    ren = 1'b1;
    tick();
    ren = 1'b0;
    chk("fwd_after_b0", rd1, 32'h01EE_DD04);

    // OREG streaming
    for (int i = 0; i < 4; i++) begin
      wen   = 4'hF;
      wadr  = 4'(i);
      wdata = 32'hA0 + 32'(i);
      tick();
    end
    wen = '0;
    for (int i = 0; i < 4; i++) begin
      ren  = 1'b1;
      radr = 4'(i);
      tick();
      if (i == 0) begin
        chk("strm_lat", 32'(rv2), 32'd0);
      end else begin
        chk("strm_rvalid", 32'(rv2), 32'd1);
        chk("strm_rdata", rd2, 32'hA0 + 32'(i - 1));
      end
    end
    ren = 1'b0;
    tick();
    chk("strm_last_rvalid", 32'(rv2), 32'd1);
    chk("strm_last_rdata", rd2, 32'hA3);
    tick();
    chk("strm_end_rvalid", 32'(rv2), 32'd0);
    chk("strm_hold", rd2, 32'hA3);

    // reset with reads in flight
    ren  = 1'b1;
    radr = 4'd5;
    tick();
    ren   = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mask_rvalid", 32'(rv0), 32'd0);
    tick();
    chk("rst_drop_oreg", 32'(rv2), 32'd0);
    chk("rst2_rdata", rd0, 32'h0);
    chk("rst2_busy", 32'(bz0), 32'd1);

    // reset mid-clear when counter is 9
    rst_n = 1'b1;
    wen   = 4'hF;
    wadr  = 4'd5;
    wdata = 32'hDEAD_BEEF;
    repeat (9) tick();
    chk("mid_busy", 32'(bz0), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    k     = 0;
    do begin
      tick();
      k++;
    end while (bz0 && k < 40);
    wen = '0;
    chk("mid_clr_len", 32'(k), 32'd16);

    for (int i = 0; i < 8; i++) begin
      ren  = 1'b1;
      radr = 4'(i);
      tick();
      chk("mid_zero", rd0, 32'h0);
      chk("mid_zero_rv", 32'(rv0), 32'd1);
    end
    ren = 1'b0;
    chk("mid_zero_b0", rd1, 32'h0);
    chk("noclr_busy_end", 32'(bz3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
